multicycle_control: RTL

Multicycle sequencer for the RISC-V core. It replaces single-cycle control with a Moore FSM that steps a shared-memory datapath (one memory, one ALU, IR/ALUOut/MDR registers) through fetch, decode, execute, memory and writeback. It supports the same instruction subset as the core: R-type, LB, SB, BEQ and ORI. Memory accesses use a ready handshake so the block can sit in front of a slow unified memory.

---
 rtl/riscv_ctrl_pkg.sv | 67 ++++++
 rtl/multicycle_ctrl_outdec.sv | 81 ++++++++
 rtl/multicycle_control.sv | 84 ++++++++
 3 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V control path: opcodes, FSM
// states, ALU/operand-select codes and the decoded control word.
package riscv_ctrl_pkg;

  localparam int OP_W    = 7;
  localparam int STATE_W = 4;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_SUB    = 2'b01;
  localparam logic [1:0] ALUOP_RFUNCT = 2'b10;
  localparam logic [1:0] ALUOP_IFUNCT = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC_R  = 4'd6,
    S_EXEC_I  = 4'd7,
    S_ALUWB   = 4'd8,
    S_BRANCH  = 4'd9,
    S_ILLEGAL = 4'd10
  } state_e;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       pc_src;
    logic       instr_done;
    logic       illegal_op;
  } ctrl_word_t;

  // Dispatch target out of DECODE; anything outside the subset traps.
  function automatic state_e decode_dispatch(input logic [6:0] opcode);
    state_e next;
    case (opcode)
      OP_RTYPE:           next = S_EXEC_R;
      OP_IMM:             next = S_EXEC_I;
      OP_LOAD, OP_STORE:  next = S_MEMADR;
      OP_BRANCH:          next = S_BRANCH;
      default:            next = S_ILLEGAL;
    endcase
    return next;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_outdec.sv
// Combinational state-to-control-word decoder. Only FETCH and MEMWR look at
// mem_ready; everything else is a pure Moore function of the state.
module multicycle_ctrl_outdec
  import riscv_ctrl_pkg::*;
(
  input  state_e     i_state,
  input  logic       i_mem_ready,
  output ctrl_word_t o_ctrl
);

  always_comb begin
    // NOTE: every field gets a default before the case so no path through
    // this block can leave a signal unassigned and infer a latch.
    o_ctrl = '0;
    case (i_state)
      S_FETCH: begin
        o_ctrl.mem_read  = 1'b1;
        o_ctrl.iord      = 1'b0;
        o_ctrl.alu_src_a = 1'b0;
        o_ctrl.alu_src_b = SRCB_FOUR;
        o_ctrl.alu_op    = ALUOP_ADD;
        o_ctrl.pc_src    = 1'b0;
        o_ctrl.ir_write  = i_mem_ready;
        o_ctrl.pc_write  = i_mem_ready;
      end
      S_DECODE: begin
        // Speculative branch target PC+imm lands in ALUOut here.
        o_ctrl.alu_src_a = 1'b0;
        o_ctrl.alu_src_b = SRCB_IMM;
        o_ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMADR: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
        o_ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        o_ctrl.mem_read = 1'b1;
        o_ctrl.iord     = 1'b1;
      end
      S_MEMWB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.mem_to_reg = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      S_MEMWR: begin
        o_ctrl.mem_write  = 1'b1;
        o_ctrl.iord       = 1'b1;
        o_ctrl.instr_done = i_mem_ready;
      end
      S_EXEC_R: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_RS2;
        o_ctrl.alu_op    = ALUOP_RFUNCT;
      end
      S_EXEC_I: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
        o_ctrl.alu_op    = ALUOP_IFUNCT;
      end
      S_ALUWB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.mem_to_reg = 1'b0;
        o_ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        o_ctrl.alu_src_a     = 1'b1;
        o_ctrl.alu_src_b     = SRCB_RS2;
        o_ctrl.alu_op        = ALUOP_SUB;
        o_ctrl.pc_write_cond = 1'b1;
        o_ctrl.pc_src        = 1'b1;
        o_ctrl.instr_done    = 1'b1;
      end
      S_ILLEGAL: begin
        o_ctrl.illegal_op = 1'b1;
      end
      default: o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle sequencer: owns the state register and next-state logic, and
// gates the decoded control word so reset silences every output at once.
module multicycle_control
  import riscv_ctrl_pkg::*;
#(
  parameter int OP_W    = 7,
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [OP_W-1:0]    op,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_en,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_write,
  output logic               mem_to_reg,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic               pc_src,
  output logic               instr_done,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state
);

  state_e     r_state;
  ctrl_word_t w_dec;
  ctrl_word_t w_ctrl;
  logic [6:0] w_opcode;

  assign w_opcode = 7'(op);

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples its inputs from before the edge, independent of block order.
    if (!rst_n) begin
      r_state <= S_FETCH;
    end else begin
      case (r_state)
        S_FETCH:   r_state <= mem_ready ? S_DECODE : S_FETCH;
        S_DECODE:  r_state <= decode_dispatch(w_opcode);
        S_MEMADR:  r_state <= (w_opcode == OP_LOAD) ? S_MEMRD : S_MEMWR;
        S_MEMRD:   r_state <= mem_ready ? S_MEMWB : S_MEMRD;
        S_MEMWB:   r_state <= S_FETCH;
        S_MEMWR:   r_state <= mem_ready ? S_FETCH : S_MEMWR;
        S_EXEC_R:  r_state <= S_ALUWB;
        S_EXEC_I:  r_state <= S_ALUWB;
        S_ALUWB:   r_state <= S_FETCH;
        S_BRANCH:  r_state <= S_FETCH;
        S_ILLEGAL: r_state <= S_ILLEGAL;
        default:   r_state <= S_FETCH;
      endcase
    end
  end

  multicycle_ctrl_outdec u_outdec (
    .i_state     (r_state),
    .i_mem_ready (mem_ready),
    .o_ctrl      (w_dec)
  );

  // Reset must kill a pending memory request or writeback in the same cycle.
  assign w_ctrl = rst_n ? w_dec : '0;

  assign pc_en      = w_ctrl.pc_write | (w_ctrl.pc_write_cond & zero);
  assign iord       = w_ctrl.iord;
  assign mem_read   = w_ctrl.mem_read;
  assign mem_write  = w_ctrl.mem_write;
  assign ir_write   = w_ctrl.ir_write;
  assign reg_write  = w_ctrl.reg_write;
  assign mem_to_reg = w_ctrl.mem_to_reg;
  assign alu_src_a  = w_ctrl.alu_src_a;
  assign alu_src_b  = w_ctrl.alu_src_b;
  assign alu_op     = w_ctrl.alu_op;
  assign pc_src     = w_ctrl.pc_src;
  assign instr_done = w_ctrl.instr_done;
  assign illegal_op = w_ctrl.illegal_op;
  assign state      = STATE_W'(r_state);

endmodule
